// File: rtl/particle_pkg.sv
// Shared types and sizing for the particle sweep controller.
package particle_pkg;

    localparam int RAM_WIDTH = 32;
    localparam int RAM_DEPTH = 1024;

    // Number of bits needed to hold 'value' (ceil(log2(value+1))).
    function automatic int clogb2(input int value);
        int v;
        int r;
        v = value;
        r = 0;
        while (v > 0) begin
            r++;
            v = v >> 1;
        end
        return r;
    endfunction

    localparam int ADDR_W = clogb2(RAM_DEPTH - 1);

    typedef struct packed {
        logic [15:0] pos_y;
        logic [15:0] pos_x;
    } particle_t;

    typedef enum logic [1:0] {IDLE, SWEEP, DRAIN, DONE} sweep_state_t;

endpackage

// File: rtl/sweep_skid_fifo.sv
// Small synchronous FIFO catching read returns; exposes its occupancy so the
// issuer can run a credit scheme against it.
module sweep_skid_fifo #(
    parameter  int DEPTH = 4,
    parameter  int W     = 42,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk_i,
    input  logic          rst_n_i,
    input  logic          flush_i,
    input  logic          push_i,
    input  logic [W-1:0]  din_i,
    input  logic          pop_i,
    output logic [W-1:0]  dout_o,
    output logic [CW-1:0] count_o
);
    localparam int            AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wp_q, rp_q;
    logic [CW-1:0] cnt_q;
    logic          do_push, do_pop;

    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign do_pop  = pop_i && (cnt_q != '0);
    assign do_push = push_i && ((cnt_q != CW'(DEPTH)) || do_pop);
    assign dout_o  = mem_q[rp_q];
    assign count_o = cnt_q;

    // Storage array, written on accepted pushes only.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wp_q] <= din_i;
    end

    // Pointers and occupancy; flush empties without touching storage.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wp_q  <= '0;
            rp_q  <= '0;
            cnt_q <= '0;
        end else if (flush_i) begin
            wp_q  <= '0;
            rp_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) wp_q <= (wp_q == LAST) ? '0 : wp_q + AW'(1);
            if (do_pop)  rp_q <= (rp_q == LAST) ? '0 : rp_q + AW'(1);
            case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + CW'(1);
                2'b01:   cnt_q <= cnt_q - CW'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule

// File: rtl/particle_sweep_ctrl.sv
// One read-modify-write pass over the particle buffer per frame: port A reads
// stream through a skid FIFO to the updater, results go back on port B.
module particle_sweep_ctrl
    import particle_pkg::*;
#(
    parameter int NUM_PARTICLES = 1024,
    parameter int READ_LATENCY  = 2,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic                 clk_in,
    input  logic                 rst_n_in,
    input  logic                 frame_start_in,
    input  logic                 abort_in,
    output logic                 busy_out,
    output logic                 done_out,
    output logic                 overrun_out,
    output logic [ADDR_W-1:0]    rd_addr_out,
    output logic                 rd_en_out,
    input  logic [RAM_WIDTH-1:0] rd_data_in,
    output logic [ADDR_W-1:0]    wr_addr_out,
    output logic [RAM_WIDTH-1:0] wr_data_out,
    output logic                 wr_en_out,
    output logic [RAM_WIDTH-1:0] upd_data_out,
    output logic [ADDR_W-1:0]    upd_addr_out,
    output logic                 upd_valid_out,
    input  logic                 upd_ready_in,
    input  logic [RAM_WIDTH-1:0] res_data_in,
    input  logic                 res_valid_in,
    output logic                 res_ready_out
);
    localparam int              CW   = $clog2(FIFO_DEPTH + 1);
    localparam int              FW   = RAM_WIDTH + ADDR_W;
    localparam logic [ADDR_W:0] LAST = (ADDR_W + 1)'(NUM_PARTICLES - 1);

    sweep_state_t                           state_q;
    logic [ADDR_W:0]                        rd_cnt_q, wr_cnt_q;
    logic [READ_LATENCY-1:0]                vld_q;
    logic [READ_LATENCY-1:0][ADDR_W-1:0]    adr_q;
    logic                                   done_q, overrun_q;
    logic                                   busy, rd_en, wr_en, pop, flush;
    logic [CW-1:0]                          fifo_cnt;
    logic [FW-1:0]                          head;
    particle_t                              head_p;
    int                                     inflight;

    assign busy  = (state_q != IDLE);
    assign flush = busy & abort_in;
    assign wr_en = busy & res_valid_in;
    assign pop   = (fifo_cnt != '0) & upd_ready_in;

    // Reads issued whose data has not yet landed in the FIFO.
    always_comb begin
        inflight = 0;
        for (int i = 0; i < READ_LATENCY; i++) inflight += int'(vld_q[i]);
    end

    // Every in-flight read owns a FIFO slot, so returns can never overflow it.
    assign rd_en = (state_q == SWEEP) && ((int'(fifo_cnt) + inflight) < FIFO_DEPTH);

    // Read-latency tracker: valid bit and address ride alongside the RAM pipe.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            vld_q <= '0;
            adr_q <= '0;
        end else begin
            vld_q[0] <= rd_en && !flush;
            adr_q[0] <= rd_cnt_q[ADDR_W-1:0];
            for (int i = 1; i < READ_LATENCY; i++) begin
                vld_q[i] <= vld_q[i-1] && !flush;
                adr_q[i] <= adr_q[i-1];
            end
        end
    end

    sweep_skid_fifo #(.DEPTH(FIFO_DEPTH), .W(FW)) u_fifo (
        .clk_i   (clk_in),
        .rst_n_i (rst_n_in),
        .flush_i (flush),
        .push_i  (vld_q[READ_LATENCY-1]),
        .din_i   ({adr_q[READ_LATENCY-1], rd_data_in}),
        .pop_i   (pop),
        .dout_o  (head),
        .count_o (fifo_cnt)
    );

    // Sweep FSM with counters and registered pulse outputs; abort wins over all.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q   <= IDLE;
            rd_cnt_q  <= '0;
            wr_cnt_q  <= '0;
            done_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            overrun_q <= frame_start_in && busy;
            done_q    <= 1'b0;
            if (rd_en) rd_cnt_q <= rd_cnt_q + (ADDR_W + 1)'(1);
            if (wr_en) wr_cnt_q <= wr_cnt_q + (ADDR_W + 1)'(1);
            if (flush) begin
                state_q <= IDLE;
            end else begin
                case (state_q)
                    IDLE: if (frame_start_in) begin
                        state_q  <= SWEEP;
                        rd_cnt_q <= '0;
                        wr_cnt_q <= '0;
                    end
                    SWEEP: if (rd_en && rd_cnt_q == LAST) state_q <= DRAIN;
                    DRAIN: if (wr_en && wr_cnt_q == LAST) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign head_p        = particle_t'(head[RAM_WIDTH-1:0]);
    assign upd_valid_out = (fifo_cnt != '0);
    assign upd_data_out  = upd_valid_out ? head_p : '0;
    assign upd_addr_out  = upd_valid_out ? head[FW-1:RAM_WIDTH] : '0;

    assign busy_out      = busy;
    assign done_out      = done_q;
    assign overrun_out   = overrun_q;
    assign rd_en_out     = rd_en;
    assign rd_addr_out   = rd_cnt_q[ADDR_W-1:0];
    assign wr_en_out     = wr_en;
    assign wr_addr_out   = wr_cnt_q[ADDR_W-1:0];
    assign wr_data_out   = wr_en ? res_data_in : '0;
    assign res_ready_out = busy;

endmodule

// File: tb/tb_particle_sweep_ctrl.sv
// Bench: two controllers (8-entry and full-depth sweeps), each with its own
// 2-cycle buffer model and a 3-cycle updater that returns data+1.
module tb_particle_sweep_ctrl;
    localparam int AW  = 10;
    localparam int NP0 = 8;
    localparam int NP1 = 1024;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic load = 1'b1;
    logic rnd = 1'b0;
    always #5 clk = ~clk;

    logic          fs [2], ab [2], rdy [2];
    logic          busy [2], done [2], ovr [2], rd_en [2], wr_en [2];
    logic          upd_v [2], res_rdy [2], res_v [2];
    logic [AW-1:0] rd_addr [2], wr_addr [2], upd_addr [2];
    logic [31:0]   rd_data [2], wr_data [2], upd_data [2], res_data [2];

    particle_sweep_ctrl #(.NUM_PARTICLES(NP0), .READ_LATENCY(2), .FIFO_DEPTH(4)) u0 (
        .clk_in(clk), .rst_n_in(rst_n), .frame_start_in(fs[0]), .abort_in(ab[0]),
        .busy_out(busy[0]), .done_out(done[0]), .overrun_out(ovr[0]),
        .rd_addr_out(rd_addr[0]), .rd_en_out(rd_en[0]), .rd_data_in(rd_data[0]),
        .wr_addr_out(wr_addr[0]), .wr_data_out(wr_data[0]), .wr_en_out(wr_en[0]),
        .upd_data_out(upd_data[0]), .upd_addr_out(upd_addr[0]), .upd_valid_out(upd_v[0]),
        .upd_ready_in(rdy[0]), .res_data_in(res_data[0]), .res_valid_in(res_v[0]),
        .res_ready_out(res_rdy[0]));

    particle_sweep_ctrl #(.NUM_PARTICLES(NP1), .READ_LATENCY(2), .FIFO_DEPTH(4)) u1 (
        .clk_in(clk), .rst_n_in(rst_n), .frame_start_in(fs[1]), .abort_in(ab[1]),
        .busy_out(busy[1]), .done_out(done[1]), .overrun_out(ovr[1]),
        .rd_addr_out(rd_addr[1]), .rd_en_out(rd_en[1]), .rd_data_in(rd_data[1]),
        .wr_addr_out(wr_addr[1]), .wr_data_out(wr_data[1]), .wr_en_out(wr_en[1]),
        .upd_data_out(upd_data[1]), .upd_addr_out(upd_addr[1]), .upd_valid_out(upd_v[1]),
        .upd_ready_in(rdy[1]), .res_data_in(res_data[1]), .res_valid_in(res_v[1]),
        .res_ready_out(res_rdy[1]));

    function automatic logic [31:0] init_val(input int i);
        return 32'h1000_0000 + 32'(i) * 32'h0001_0001;
    endfunction

    function automatic int np(input int k);
        return (k == 0) ? NP0 : NP1;
    endfunction

    // ---------------- buffer and updater environment ----------------
    logic [31:0] mem [2][1024];
    logic [31:0] r1 [2];
    logic [2:0]  sv [2];
    logic [31:0] sd [2][3];

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (load) begin
                for (int i = 0; i < 1024; i++) mem[k][i] <= init_val(i);
            end else if (wr_en[k]) begin
                mem[k][wr_addr[k]] <= wr_data[k];
            end
            if (rd_en[k]) r1[k] <= mem[k][rd_addr[k]];
            rd_data[k] <= r1[k];
            sv[k]    <= {sv[k][1:0], upd_v[k] & rdy[k]};
            sd[k][0] <= upd_data[k] + 32'd1;
            sd[k][1] <= sd[k][0];
            sd[k][2] <= sd[k][1];
        end
    end

    assign res_v[0]    = sv[0][2];
    assign res_v[1]    = sv[1][2];
    assign res_data[0] = sd[0][2];
    assign res_data[1] = sd[1][2];

    // ---------------- checking ----------------
    int checks = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Observable sweep model: a sweep is "busy" from the start request until
    // the cycle after the last write-back, or until an abort.
    bit          busy_m [2], done_m [2], ovr_m [2], prev_st [2];
    int          rd_m [2], wr_m [2], nxt_upd [2], done_cnt [2], ovr_cnt [2];
    logic [31:0] snap [2][1024];
    logic [31:0] pd [2];
    logic [AW-1:0] pa [2];

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (!rst_n) begin
                busy_m[k] = 0; done_m[k] = 0; ovr_m[k] = 0; prev_st[k] = 0;
            end else begin
                bit nb, nd;
                chk("busy", busy[k], busy_m[k]);
                chk("done", done[k], done_m[k]);
                chk("overrun", ovr[k], ovr_m[k]);
                chk("res_ready", res_rdy[k], busy_m[k]);
                chk("wr_en", wr_en[k], busy_m[k] & res_v[k]);
                if (done[k]) done_cnt[k]++;
                if (ovr[k]) ovr_cnt[k]++;
                if (wr_en[k]) begin
                    chk("wr_addr", wr_addr[k], wr_m[k]);
                    chk("wr_data", wr_data[k], res_data[k]);
                    chk("wr_after_rd", wr_m[k] < rd_m[k], 1);
                end
                if (rd_en[k]) begin
                    chk("rd_addr", rd_addr[k], rd_m[k]);
                    chk("rd_range", rd_m[k] < np(k), 1);
                    if (wr_en[k]) chk("port_clash", rd_addr[k] == wr_addr[k], 0);
                end
                if (!busy_m[k]) begin
                    chk("idle_rd_en", rd_en[k], 0);
                    chk("idle_upd_v", upd_v[k], 0);
                end
                if (prev_st[k] && busy_m[k]) begin
                    chk("stall_valid", upd_v[k], 1);
                    chk("stall_data", upd_data[k], pd[k]);
                    chk("stall_addr", upd_addr[k], pa[k]);
                end
                if (upd_v[k] && rdy[k]) begin
                    chk("upd_addr", upd_addr[k], nxt_upd[k]);
                    chk("upd_data", upd_data[k], snap[k][nxt_upd[k] % 1024]);
                    nxt_upd[k]++;
                end
                if (done_m[k]) begin
                    chk("done_reads", rd_m[k], np(k));
                    chk("done_delivered", nxt_upd[k], np(k));
                    chk("done_writes", wr_m[k], np(k));
                end
                prev_st[k] = upd_v[k] & !rdy[k];
                pd[k] = upd_data[k];
                pa[k] = upd_addr[k];
                // advance to next cycle
                if (rd_en[k]) rd_m[k]++;
                if (wr_en[k]) wr_m[k]++;
                ovr_m[k] = fs[k] && busy_m[k];
                nb = busy_m[k];
                nd = 0;
                if (busy_m[k] && ab[k]) nb = 0;
                else if (!busy_m[k]) begin
                    if (fs[k]) begin
                        nb = 1; rd_m[k] = 0; wr_m[k] = 0; nxt_upd[k] = 0;
                        for (int i = 0; i < 1024; i++) snap[k][i] = mem[k][i];
                    end
                end
                else if (done_m[k]) nb = 0;
                else if (wr_en[k] && wr_m[k] == np(k)) nd = 1;
                busy_m[k] = nb;
                done_m[k] = nd;
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        forever begin
            @(posedge clk); #1;
            for (int k = 0; k < 2; k++) rdy[k] = rnd ? ($urandom_range(0, 9) < 3) : 1'b1;
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic pulse_fs(input int k);
        fs[k] = 1'b1; cyc(1); fs[k] = 1'b0;
    endtask

    task automatic wait_idle(input int k, input int budget);
        int n = 0;
        while (busy[k] && n < budget) begin cyc(1); n++; end
        chk("sweep_timeout", busy[k], 0);
    endtask

    task automatic wait_rd(input int k, input int a);
        int n = 0;
        while (!(rd_en[k] && rd_addr[k] == AW'(a)) && n < 100) begin cyc(1); n++; end
        chk("wait_rd_timeout", n < 100, 1);
    endtask

    task automatic check_mem(input int k, input string nm);
        int bad = 0;
        for (int i = 0; i < np(k); i++) if (mem[k][i] !== snap[k][i] + 32'd1) bad++;
        chk(nm, bad, 0);
    endtask

    task automatic check_zero(input int k, input string nm);
        chk({nm, "_ctl"}, {busy[k], done[k], ovr[k], rd_en[k], wr_en[k], upd_v[k], res_rdy[k]}, 0);
        chk({nm, "_addr"}, {rd_addr[k], wr_addr[k], upd_addr[k]}, 0);
        chk({nm, "_data"}, {wr_data[k], upd_data[k]}, 0);
    endtask

    initial begin
        int dc, oc, wrs;
        for (int k = 0; k < 2; k++) begin fs[k] = 0; ab[k] = 0; rdy[k] = 1; end
        #1;
        check_zero(0, "reset0");
        check_zero(1, "reset1");
        cyc(3);
        load = 1'b0;
        rst_n = 1'b1;
        cyc(2);

        // 1: basic 8-entry sweep, ready always high
        dc = done_cnt[0];
        pulse_fs(0);
        wait_idle(0, 200);
        chk("t1_done_pulses", done_cnt[0] - dc, 1);
        check_mem(0, "t1_mem");
        chk("t1_mem0", mem[0][0], 32'h1000_0001);
        chk("t1_mem5", mem[0][5], 32'h1005_0006);
        chk("t1_untouched8", mem[0][8], 32'h1008_0008);

        // 2: updater stalls ~70% of cycles
        rnd = 1'b1;
        pulse_fs(0);
        wait_idle(0, 600);
        rnd = 1'b0;
        check_mem(0, "t2_mem");
        chk("t2_mem7", mem[0][7], 32'h1007_0009);

        // 3: frame start while busy
        dc = done_cnt[0];
        oc = ovr_cnt[0];
        pulse_fs(0);
        cyc(4);
        pulse_fs(0);
        wait_idle(0, 200);
        cyc(2);
        chk("t3_overrun_pulses", ovr_cnt[0] - oc, 1);
        chk("t3_done_pulses", done_cnt[0] - dc, 1);
        chk("t3_busy_after", busy[0], 0);
        check_mem(0, "t3_mem");
        chk("t3_mem0", mem[0][0], 32'h1000_0003);
        chk("t3_untouched8", mem[0][8], 32'h1008_0008);

        // 4: abort once rd_cnt has reached 5, then a clean sweep
        dc = done_cnt[0];
        pulse_fs(0);
        wait_rd(0, 4);
        cyc(1);
        ab[0] = 1'b1; cyc(1); ab[0] = 1'b0;
        chk("t4_idle_after_abort", busy[0], 0);
        cyc(6);
        chk("t4_no_done", done_cnt[0] - dc, 0);
        pulse_fs(0);
        wait_idle(0, 200);
        chk("t4_done_pulses", done_cnt[0] - dc, 1);
        check_mem(0, "t4_mem");

        // 5: full-depth sweep
        dc = done_cnt[1];
        pulse_fs(1);
        wait_idle(1, 4000);
        chk("t5_done_pulses", done_cnt[1] - dc, 1);
        chk("t5_reads", rd_m[1], 1024);
        chk("t5_writes", wr_m[1], 1024);
        check_mem(1, "t5_mem");
        chk("t5_mem1023", mem[1][1023], 32'h13ff_0400);
        chk("t5_mem0", mem[1][0], 32'h1000_0001);

        // 6: asynchronous reset while draining
        pulse_fs(0);
        wait_rd(0, 7);
        cyc(1);
        #1 rst_n = 1'b0;
        #1 check_zero(0, "t6_reset");
        cyc(2);
        rst_n = 1'b1;
        wrs = 0;
        for (int i = 0; i < 10; i++) begin cyc(1); if (wr_en[0]) wrs++; end
        chk("t6_no_wr_after_reset", wrs, 0);
        chk("t6_idle", busy[0], 0);
        dc = done_cnt[0];
        pulse_fs(0);
        wait_idle(0, 200);
        chk("t6_done_pulses", done_cnt[0] - dc, 1);
        check_mem(0, "t6_mem");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

endmodule
